param_countdown_processor: RTL

//  Parametrised successor of the 4-bit countdown processor. Loads an immediate

---
 rtl/cdp_pkg.sv | 23 ++
 rtl/cdp_datapath.sv | 54 +++++
 rtl/param_countdown_processor.sv | 110 +++++++++++
 3 files changed

// File: rtl/cdp_pkg.sv
// Shared types for the parametrised countdown processor.
// The auto-reload option is selected with the CDP_AUTO_RELOAD_EN macro.
package cdp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    LOAD = 2'd1,
    DEC  = 2'd2
  } op_sel_t;

`ifdef CDP_AUTO_RELOAD_EN
  localparam bit RELOAD_EN = 1'b1;
`else
  localparam bit RELOAD_EN = 1'b0;
`endif

endpackage

// File: rtl/cdp_datapath.sv
// X/Y registers of the countdown processor: saturating decrement of x,
// step counter y and zero detection, steered by the controller's op_sel/enables.
module cdp_datapath
  import cdp_pkg::*;
#(
  parameter int          WIDTH = 4,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  op_sel_t          op_sel,
  input  logic             en_x,
  input  logic             en_y,
  input  logic             y_clr,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             dec_zero
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  // Clamp at zero instead of wrapping when the remaining count is below STEP.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
    return (v > STEP_W) ? v - STEP_W : '0;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x <= '0;
    end else if (en_x) begin
      case (op_sel)
        LOAD:    x <= load_val;
        DEC:     x <= sat_dec(x);
        default: x <= x;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y <= '0;
    end else if (y_clr) begin
      y <= '0;
    end else if (en_y) begin
      y <= y + WIDTH'(1);
    end
  end

  assign zero     = (x == '0);
  assign dec_zero = (sat_dec(x) == '0);

endmodule

// File: rtl/param_countdown_processor.sv
// Countdown processor top: start/abort controller driving cdp_datapath.
// Define CDP_AUTO_RELOAD_EN to make DONE reload from the captured immediate.
module param_countdown_processor
  import cdp_pkg::*;
#(
  parameter int          WIDTH = 4,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  state_t           state, state_next;
  op_sel_t          op_sel;
  logic             en_x, en_y, y_clr, dec_zero;
  logic [WIDTH-1:0] load_val;
`ifdef CDP_AUTO_RELOAD_EN
  logic [WIDTH-1:0] imm_q;
`endif

  always_comb begin
    state_next = state;
    op_sel     = HOLD;
    en_x       = 1'b0;
    en_y       = 1'b0;
    y_clr      = 1'b0;
    load_val   = imm;
    case (state)
      IDLE: begin
        if (!abort && start) begin
          op_sel     = LOAD;
          en_x       = 1'b1;
          y_clr      = 1'b1;
          state_next = (imm == '0) ? DONE : COUNT;
        end
      end
      COUNT: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          op_sel = DEC;
          en_x   = 1'b1;
          en_y   = 1'b1;
          if (dec_zero) state_next = DONE;
        end
      end
      DONE: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
`ifdef CDP_AUTO_RELOAD_EN
          op_sel     = LOAD;
          en_x       = 1'b1;
          y_clr      = 1'b1;
          load_val   = imm_q;
          state_next = (imm_q == '0) ? DONE : COUNT;
`else
          state_next = IDLE;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // busy/done are derived from the next state so they line up with x/y.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef CDP_AUTO_RELOAD_EN
      imm_q <= '0;
`endif
    end else begin
      state <= state_next;
      done  <= (state_next == DONE);
      busy  <= RELOAD_EN ? (state_next != IDLE) : (state_next == COUNT);
`ifdef CDP_AUTO_RELOAD_EN
      if (state == IDLE && start && !abort) imm_q <= imm;
`endif
    end
  end

  cdp_datapath #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_datapath (
    .clk      (clk),
    .reset    (reset),
    .op_sel   (op_sel),
    .en_x     (en_x),
    .en_y     (en_y),
    .y_clr    (y_clr),
    .load_val (load_val),
    .x        (x),
    .y        (y),
    .zero     (zero),
    .dec_zero (dec_zero)
  );

endmodule
